remote_req_queue: RTL and testbench

REMOTE_REQ_QUEUE -- requirements
Module: remote_req_queue

---
 rtl/remote_req_queue_if.sv | 28 ++
 rtl/remote_req_queue.sv | 116 +++++++++++
 tb/tb_remote_req_queue.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/remote_req_queue_if.sv
// Request channel between the load/store unit, the remote request queue and network TX.
// The master side feeds requests and consumes the head; the slave side is the queue.
interface remote_req_queue_if #(
    parameter int unsigned data_width_p = 32
);
    typedef struct packed {
        logic                    write_not_read;
        logic [data_width_p-1:0] addr;
        logic [data_width_p-1:0] data;
    } remote_req_s;

    remote_req_s req_in;
    logic        req_in_v;
    logic        ready;
    remote_req_s req_out;
    logic        req_out_v;
    logic        req_out_yumi;

    modport master (
        output req_in, req_in_v, req_out_yumi,
        input  ready, req_out, req_out_v
    );

    modport slave (
        input  req_in, req_in_v, req_out_yumi,
        output ready, req_out, req_out_v
    );
endinterface

// File: rtl/remote_req_queue.sv
// Credit-limited FIFO of outbound remote requests with a fence that stalls the
// pipeline until the queue is empty and every outstanding credit has come back.
module remote_req_queue #(
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned els_p             = 2,
    parameter int unsigned max_out_credits_p = 32,
    localparam int unsigned credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    remote_req_queue_if.slave          rq_io,
    input  logic                       credit_return_i,
    input  logic                       fence_req_i,
    output logic                       fence_stall_o,
    output logic [credit_width_lp-1:0] out_credits_o,
    output logic                       empty_o
);
    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned req_width_lp = 2 * data_width_p + 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;
    typedef logic [ptr_width_lp:0]   cnt_t;
    typedef logic [credit_width_lp-1:0] credit_t;

    localparam cnt_t    els_lp         = cnt_t'(els_p);
    localparam credit_t max_credits_lp = credit_t'(max_out_credits_p);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    logic [req_width_lp-1:0] mem_q [els_p];
    ptr_t    wptr_q, wptr_d, rptr_q, rptr_d;
    cnt_t    count_q, count_d;
    credit_t credits_q, credits_d;
    state_e  state_q;

    logic full, empty, drained, head_v, enq, deq;

    always_comb begin
        full    = (count_q == els_lp);
        empty   = (count_q == '0);
        drained = empty && (credits_q == max_credits_lp);
        head_v  = !empty && (credits_q != '0);
        enq     = rq_io.req_in_v && !full && !reset_i;
        // Yumi without a valid head is ignored rather than corrupting state.
        deq     = rq_io.req_out_yumi && head_v && !reset_i;

        wptr_d = enq ? wptr_q + ptr_t'(1) : wptr_q;
        rptr_d = deq ? rptr_q + ptr_t'(1) : rptr_q;

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        credits_d = credits_q;
        case ({deq, credit_return_i})
            2'b10:   credits_d = credits_q - credit_t'(1);
            2'b01:   credits_d = (credits_q == max_credits_lp) ? credits_q
                                                               : credits_q + credit_t'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        rq_io.ready     = !full || reset_i;
        rq_io.req_out_v = head_v && !reset_i;
        rq_io.req_out   = mem_q[rptr_q];
        empty_o         = empty || reset_i;
        out_credits_o   = credits_q;
        fence_stall_o   = !reset_i && !drained && ((state_q == StDrain) || fence_req_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            credits_q <= max_credits_lp;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= rq_io.req_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:  if (fence_req_i && !drained) state_q <= StDrain;
                StDrain: if (drained) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(rq_io.req_out_yumi && !head_v))
                else $error("remote_req_queue: yumi while head not valid");
            assert (!(credit_return_i && (credits_q == max_credits_lp)))
                else $error("remote_req_queue: credit returned while credits at maximum");
        end
    end
endmodule

// File: tb/tb_remote_req_queue.sv
// Directed bench for remote_req_queue: enqueue/dequeue, credit limiting, fence drain
// and reset recovery, with hand-computed expectations.
module tb_remote_req_queue;
    logic       clk = 1'b0;
    logic       reset;
    logic       credit_return;
    logic       fence_req;
    logic       fence_stall;
    logic       empty;
    logic [5:0] out_credits;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    remote_req_queue_if #(.data_width_p(32)) rq ();

    remote_req_queue #(
        .data_width_p     (32),
        .els_p            (2),
        .max_out_credits_p(32)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .rq_io          (rq),
        .credit_return_i(credit_return),
        .fence_req_i    (fence_req),
        .fence_stall_o  (fence_stall),
        .out_credits_o  (out_credits),
        .empty_o        (empty)
    );

    localparam logic [64:0] P1 = {1'b1, 32'h1000_0004, 32'hDEAD_BEEF};
    localparam logic [64:0] P2 = {1'b0, 32'h2000_0008, 32'h0000_0000};
    localparam logic [64:0] P3 = {1'b1, 32'h3000_000C, 32'h1234_5678};
    localparam logic [64:0] P4 = {1'b1, 32'h4000_0010, 32'hCAFE_F00D};
    localparam logic [64:0] Q1 = {1'b0, 32'h5000_0014, 32'hA5A5_A5A5};
    localparam logic [64:0] Q2 = {1'b1, 32'h6000_0018, 32'h5A5A_5A5A};
    localparam logic [64:0] R1 = {1'b1, 32'h7000_001C, 32'h0BAD_CAFE};
    localparam logic [64:0] R2 = {1'b0, 32'h8000_0020, 32'hFFFF_0000};
    localparam logic [64:0] S1 = {1'b1, 32'h9000_0024, 32'h0F0F_0F0F};

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic enq(input logic [64:0] r);
        rq.req_in   = r;
        rq.req_in_v = 1'b1;
        tick();
        rq.req_in_v = 1'b0;
    endtask

    // Enqueue into an empty queue, then consume it the following cycle.
    task automatic issue(input int i);
        logic [31:0] v;
        v = 32'(i);
        enq({1'b0, v, ~v});
        rq.req_out_yumi = 1'b1;
        tick();
        rq.req_out_yumi = 1'b0;
    endtask

    task automatic ret();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        credit_return   = 1'b0;
        fence_req       = 1'b0;
        rq.req_in       = '0;
        rq.req_in_v     = 1'b0;
        rq.req_out_yumi = 1'b0;
        tick();
        tick();
        settle();
        check("rst_ready",  rq.ready,     1);
        check("rst_v",      rq.req_out_v, 0);
        check("rst_stall",  fence_stall,  0);
        check("rst_empty",  empty,        1);
        reset = 1'b0;
        settle();
        check("post_rst_credits", out_credits, 32);
        check("post_rst_empty",   empty,       1);
        check("post_rst_ready",   rq.ready,    1);
        check("post_rst_v",       rq.req_out_v, 0);

        // Single store: visible one cycle after enqueue, credit spent on yumi.
        enq(P1);
        settle();
        check("single_v",       rq.req_out_v, 1);
        check("single_payload", rq.req_out,   P1);
        check("single_credits", out_credits,  32);
        rq.req_out_yumi = 1'b1;
        tick();
        rq.req_out_yumi = 1'b0;
        settle();
        check("single_credits_after", out_credits, 31);
        check("single_empty_after",   empty,       1);
        check("single_v_after",       rq.req_out_v, 0);

        // Three back-to-back enqueues against a two-entry queue.
        rq.req_in   = P2;
        rq.req_in_v = 1'b1;
        tick();
        rq.req_in = P3;
        settle();
        check("b2b_ready_one", rq.ready, 1);
        tick();
        rq.req_in = P4;
        settle();
        check("b2b_ready_full", rq.ready, 0);
        tick();
        settle();
        check("b2b_still_full", rq.ready,   0);
        check("b2b_head_p2",    rq.req_out, P2);
        rq.req_out_yumi = 1'b1;
        tick();
        rq.req_out_yumi = 1'b0;
        settle();
        check("b2b_ready_after_yumi", rq.ready,   1);
        check("b2b_head_p3",          rq.req_out, P3);
        tick();
        rq.req_in_v = 1'b0;
        settle();
        check("b2b_third_accepted", rq.ready,   0);
        check("b2b_head_still_p3",  rq.req_out, P3);
        rq.req_out_yumi = 1'b1;
        tick();
        settle();
        check("b2b_head_p4", rq.req_out, P4);
        tick();
        rq.req_out_yumi = 1'b0;
        settle();
        check("b2b_drained_empty",   empty,       1);
        check("b2b_drained_credits", out_credits, 28);

        // Simultaneous yumi and credit return at credits == 10.
        for (int i = 0; i < 18; i++) issue(i);
        settle();
        check("credits_at_10", out_credits, 10);
        enq(P1);
        rq.req_out_yumi = 1'b1;
        credit_return   = 1'b1;
        tick();
        rq.req_out_yumi = 1'b0;
        credit_return   = 1'b0;
        settle();
        check("yumi_ret_credits", out_credits, 10);
        check("yumi_ret_empty",   empty,       1);

        // Exhaust credits: head held, queue fills, issue resumes after a return.
        for (int i = 0; i < 10; i++) issue(100 + i);
        settle();
        check("credits_zero", out_credits, 0);
        enq(Q1);
        settle();
        check("zero_cred_v",     rq.req_out_v, 0);
        check("zero_cred_empty", empty,        0);
        enq(Q2);
        settle();
        check("zero_cred_full",  rq.ready,     0);
        check("zero_cred_v2",    rq.req_out_v, 0);
        credit_return = 1'b1;
        settle();
        check("no_issue_in_return_cycle", rq.req_out_v, 0);
        tick();
        credit_return = 1'b0;
        settle();
        check("return_credits", out_credits,  1);
        check("return_v",       rq.req_out_v, 1);
        check("return_head_q1", rq.req_out,   Q1);
        rq.req_out_yumi = 1'b1;
        tick();
        rq.req_out_yumi = 1'b0;
        settle();
        check("q2_held_v",     rq.req_out_v, 0);
        check("q2_held_head",  rq.req_out,   Q2);
        check("q2_held_ready", rq.ready,     1);
        for (int i = 0; i < 30; i++) ret();
        settle();
        check("refill_credits", out_credits,  30);
        check("refill_v",       rq.req_out_v, 1);

        // Fence with 2 outstanding and 1 queued.
        fence_req = 1'b1;
        settle();
        check("fence_stall_entry", fence_stall, 1);
        tick();
        fence_req = 1'b0;
        settle();
        check("fence_stall_drain", fence_stall, 1);
        check("fence_head_q2",     rq.req_out,  Q2);
        rq.req_out_yumi = 1'b1;
        tick();
        rq.req_out_yumi = 1'b0;
        settle();
        check("fence_empty",        empty,       1);
        check("fence_credits_29",   out_credits, 29);
        check("fence_stall_29",     fence_stall, 1);
        ret();
        ret();
        settle();
        check("fence_stall_31", fence_stall, 1);
        check("fence_credits_31", out_credits, 31);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        settle();
        check("fence_credits_32", out_credits, 32);
        check("fence_released",   fence_stall, 0);
        tick();
        fence_req = 1'b1;
        settle();
        check("fence_when_drained", fence_stall, 0);
        tick();
        fence_req = 1'b0;
        settle();
        check("fence_stays_idle", fence_stall, 0);

        // Reset with 2 queued, 5 outstanding and a pending fence.
        for (int i = 0; i < 5; i++) issue(200 + i);
        enq(R1);
        enq(R2);
        settle();
        check("pre_rst_empty",   empty,       0);
        check("pre_rst_full",    rq.ready,    0);
        check("pre_rst_credits", out_credits, 27);
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        settle();
        check("pre_rst_stall", fence_stall, 1);
        reset = 1'b1;
        settle();
        check("mid_rst_ready", rq.ready,     1);
        check("mid_rst_v",     rq.req_out_v, 0);
        check("mid_rst_stall", fence_stall,  0);
        check("mid_rst_empty", empty,        1);
        tick();
        reset = 1'b0;
        settle();
        check("after_rst_empty",   empty,        1);
        check("after_rst_credits", out_credits,  32);
        check("after_rst_stall",   fence_stall,  0);
        check("after_rst_v",       rq.req_out_v, 0);
        enq(S1);
        settle();
        check("after_rst_head", rq.req_out,   S1);
        check("after_rst_v2",   rq.req_out_v, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
